// File: rtl/ro_slot_sched_pkg.sv
// Shared types and helpers for the readout slot scheduler.
// Holds FSM encoding, default sizes and the slot-owner function.
package ro_slot_sched_pkg;

  localparam int N_CH_DEF = 4;
  localparam int CHW_DEF  = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Owner of slot c is ctz(c+1); the result n marks the idle slot.
  function automatic logic [31:0] slot_owner(
    input logic [31:0] c,
    input logic [31:0] n
  );
    logic [31:0] nxt;
    logic [31:0] r;
    nxt = c + 32'd1;
    r   = n;
    for (int i = 31; i >= 0; i--) begin
      if (unsigned'(i) < n && nxt[i]) r = unsigned'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ro_slot_decode.sv
// Maps a slot counter value and channel mask to a one-hot grant.
// Ports: cnt_i/mask_i in; grant_o, owner_o, valid_o out (comb).
module ro_slot_decode
  import ro_slot_sched_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int CHW  = CHW_DEF
) (
  input  logic [N_CH-1:0] cnt_i,
  input  logic [N_CH-1:0] mask_i,
  output logic [N_CH-1:0] grant_o,
  output logic [CHW-1:0]  owner_o,
  output logic            valid_o
);

  logic [31:0]    own;
  logic           idle;
  logic [CHW-1:0] own_c;

  always_comb begin
    own     = slot_owner(32'(cnt_i), 32'(N_CH));
    idle    = (own == 32'(N_CH));
    own_c   = own[CHW-1:0];
    valid_o = !idle && mask_i[own_c];
    grant_o = '0;
    owner_o = '0;
    if (valid_o) begin
      grant_o[own_c] = 1'b1;
      owner_o        = own_c;
    end
  end

endmodule

// File: rtl/ro_slot_sched.sv
// Gray-order readout scheduler sharing one output pair across N_CH
// channels. Ports: clk_master, rst, en, ch_mask, in_eve, in_pol_eve
// in; grant, out_eve, out_pol_eve, out_valid, out_ch, frame_start,
// busy out (all registered).
module ro_slot_sched
  import ro_slot_sched_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int CHW  = CHW_DEF
) (
  input  logic            clk_master,
  input  logic            rst,
  input  logic            en,
  input  logic [N_CH-1:0] ch_mask,
  input  logic [N_CH-1:0] in_eve,
  input  logic [N_CH-1:0] in_pol_eve,
  output logic [N_CH-1:0] grant,
  output logic            out_eve,
  output logic            out_pol_eve,
  output logic            out_valid,
  output logic [CHW-1:0]  out_ch,
  output logic            frame_start,
  output logic            busy
);

  localparam logic [N_CH-1:0] LAST = '1;

  state_e          state_q, state_d;
  logic [N_CH-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0] mask_q, mask_d;
  logic            start_d;
  logic            in_frame_d;

  logic [N_CH-1:0] grant_q;
  logic [CHW-1:0]  own_q;
  logic            eve_q, pol_q, valid_q;
  logic [CHW-1:0]  ch_q;
  logic            start_q, busy_q;

  logic [N_CH-1:0] g_nx;
  logic [CHW-1:0]  o_nx;
  logic            v_nx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    start_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_RUN;
          cnt_d   = '0;
          mask_d  = ch_mask;
          start_d = 1'b1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          if (en) begin
            mask_d  = ch_mask;
            start_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (!en) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    in_frame_d = (state_d != S_IDLE);
  end

  // Grant for the upcoming cycle is decoded from next-state values
  // so it can be registered and still line up with frame cycle c.
  ro_slot_decode #(
    .N_CH (N_CH),
    .CHW  (CHW)
  ) u_dec (
    .cnt_i   (cnt_d),
    .mask_i  (mask_d),
    .grant_o (g_nx),
    .owner_o (o_nx),
    .valid_o (v_nx)
  );

  always_ff @(posedge clk_master) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      grant_q <= '0;
      own_q   <= '0;
      eve_q   <= 1'b0;
      pol_q   <= 1'b0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      grant_q <= (in_frame_d && v_nx) ? g_nx : '0;
      own_q   <= (in_frame_d && v_nx) ? o_nx : '0;
      valid_q <= |grant_q;
      ch_q    <= own_q;
      eve_q   <= (|grant_q) & in_eve[own_q];
      pol_q   <= (|grant_q) & in_pol_eve[own_q];
      start_q <= start_d;
      busy_q  <= in_frame_d;
    end
  end

  assign grant       = grant_q;
  assign out_eve     = eve_q;
  assign out_pol_eve = pol_q;
  assign out_valid   = valid_q;
  assign out_ch      = ch_q;
  assign frame_start = start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ro_slot_sched.sv
// Directed bench for ro_slot_sched with N_CH=4 (16-cycle frames).
// Walks reset, full/masked frames, en drop, mid-frame rst, random.
module tb_ro_slot_sched;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] ch_mask, in_eve, in_pol_eve;
  logic [3:0] grant;
  logic       out_eve, out_pol_eve, out_valid;
  logic [1:0] out_ch;
  logic       frame_start, busy;

  always #5 clk = ~clk;

  ro_slot_sched #(.N_CH(4), .CHW(2)) dut (
    .clk_master  (clk),
    .rst         (rst),
    .en          (en),
    .ch_mask     (ch_mask),
    .in_eve      (in_eve),
    .in_pol_eve  (in_pol_eve),
    .grant       (grant),
    .out_eve     (out_eve),
    .out_pol_eve (out_pol_eve),
    .out_valid   (out_valid),
    .out_ch      (out_ch),
    .frame_start (frame_start),
    .busy        (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int pat[16] = '{0,1,0,2,0,1,0,3,0,1,0,2,0,1,0,4};
  logic [3:0] eve_v = 4'b0101;
  logic [3:0] pol_v = 4'b0011;
  logic       pv;
  logic [1:0] pch;
  int         gcnt[4];
  logic       prev_rst;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_ch"}, 32'(out_ch), 0);
    chk({tag, "_eve"}, 32'(out_eve), 0);
    chk({tag, "_pol"}, 32'(out_pol_eve), 0);
    chk({tag, "_fs"}, 32'(frame_start), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Checks one frame cycle against the hand-written slot table.
  task automatic check_slot(input int c, input logic [3:0] m);
    logic [2:0] own;
    logic [3:0] eg;
    own = 3'(pat[c]);
    eg  = '0;
    if (own < 3'd4 && m[own[1:0]]) eg[own[1:0]] = 1'b1;
    chk($sformatf("grant_c%0d", c), 32'(grant), 32'(eg));
    chk($sformatf("fs_c%0d", c), 32'(frame_start), 32'(c == 0));
    chk($sformatf("busy_c%0d", c), 32'(busy), 1);
    chk($sformatf("valid_c%0d", c), 32'(out_valid), 32'(pv));
    chk($sformatf("ch_c%0d", c), 32'(out_ch),
        pv ? 32'(pch) : 0);
    chk($sformatf("eve_c%0d", c), 32'(out_eve),
        pv ? 32'(eve_v[pch]) : 0);
    chk($sformatf("pol_c%0d", c), 32'(out_pol_eve),
        pv ? 32'(pol_v[pch]) : 0);
    for (int i = 0; i < 4; i++) gcnt[i] += int'(grant[i]);
    pv  = (eg != 4'b0);
    pch = own[1:0];
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    ch_mask    = 4'b0000;
    in_eve     = eve_v;
    in_pol_eve = pol_v;
    pv         = 1'b0;
    pch        = 2'd0;
    prev_rst   = 1'b0;
    step();
    step();
    chk_zero("reset");

    rst     = 1'b0;
    en      = 1'b1;
    ch_mask = 4'b1111;
    step();

    // Frame A: all channels enabled.
    for (int i = 0; i < 4; i++) gcnt[i] = 0;
    for (int c = 0; c < 16; c++) begin
      check_slot(c, 4'b1111);
      if (c == 15) ch_mask = 4'b1110;
      step();
    end
    chk("cnt_ch0", 32'(gcnt[0]), 8);
    chk("cnt_ch1", 32'(gcnt[1]), 4);
    chk("cnt_ch2", 32'(gcnt[2]), 2);
    chk("cnt_ch3", 32'(gcnt[3]), 1);

    // Frame B: ch0 masked; mid-frame change to 0000 is deferred.
    for (int c = 0; c < 16; c++) begin
      check_slot(c, 4'b1110);
      if (c == 6) ch_mask = 4'b0000;
      step();
    end

    // Frame C: everything masked.
    for (int c = 0; c < 16; c++) begin
      check_slot(c, 4'b0000);
      if (c == 15) ch_mask = 4'b1111;
      step();
    end

    // Frame D: en dropped at cycle 5, frame still completes.
    for (int c = 0; c < 16; c++) begin
      check_slot(c, 4'b1111);
      if (c == 5) en = 1'b0;
      step();
    end
    for (int k = 0; k < 3; k++) begin
      chk_zero($sformatf("idle%0d", k));
      step();
    end

    // Frame E: rst pulsed at cycle 9.
    en = 1'b1;
    step();
    pv = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check_slot(c, 4'b1111);
      if (c == 9) rst = 1'b1;
      step();
    end
    chk_zero("midrst");
    rst = 1'b0;
    step();
    pv = 1'b0;
    check_slot(0, 4'b1111);
    step();
    check_slot(1, 4'b1111);

    // Random en/mask/rst: grant must stay one-hot-or-zero.
    for (int k = 0; k < 2000; k++) begin
      en       = ($urandom_range(0, 3) != 0);
      ch_mask  = 4'($urandom);
      rst      = ($urandom_range(0, 99) == 0);
      prev_rst = rst;
      step();
      chk("onehot0", 32'($onehot0(grant)), 1);
      if (prev_rst) chk_zero("rnd_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
